// File: rtl/vjtag_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vjtag_pkg
// Description : TAP state encodings and user IR width limits for virtual_jtag.
// Revision    : 1.0 - initial release
// ============================================================================
package vjtag_pkg;

    typedef logic [3:0] tap_state_t;

    localparam tap_state_t c_st_tlr   = 4'hF;
    localparam tap_state_t c_st_rti   = 4'hC;
    localparam tap_state_t c_st_seldr = 4'h7;
    localparam tap_state_t c_st_cdr   = 4'h6;
    localparam tap_state_t c_st_sdr   = 4'h2;
    localparam tap_state_t c_st_e1dr  = 4'h1;
    localparam tap_state_t c_st_pdr   = 4'h3;
    localparam tap_state_t c_st_e2dr  = 4'h0;
    localparam tap_state_t c_st_udr   = 4'h5;
    localparam tap_state_t c_st_selir = 4'h4;
    localparam tap_state_t c_st_cir   = 4'hE;
    localparam tap_state_t c_st_sir   = 4'hA;
    localparam tap_state_t c_st_e1ir  = 4'h9;
    localparam tap_state_t c_st_pir   = 4'hB;
    localparam tap_state_t c_st_e2ir  = 4'h8;
    localparam tap_state_t c_st_uir   = 4'hD;

    localparam int c_ir_width_min = 1;
    localparam int c_ir_width_max = 16;

endpackage
`default_nettype wire

// File: rtl/vjtag_tap_fsm.sv
`default_nettype none
// ============================================================================
// Module      : vjtag_tap_fsm
// Description : IEEE 1149.1 TAP controller with one-hot virtual state decodes.
// Revision    : 1.0 - initial release
// ============================================================================
module vjtag_tap_fsm
    import vjtag_pkg::*;
(
    input  logic       tck,
    input  logic       reset,
    input  logic       i_tms,
    output logic [3:0] o_state,
    output logic       o_cdr,
    output logic       o_sdr,
    output logic       o_e1dr,
    output logic       o_pdr,
    output logic       o_e2dr,
    output logic       o_udr,
    output logic       o_cir,
    output logic       o_uir
);

    tap_state_t r_state;
    tap_state_t w_next;

    always_comb begin
        w_next = c_st_tlr;
        case (r_state)
            c_st_tlr:   w_next = i_tms ? c_st_tlr   : c_st_rti;
            c_st_rti:   w_next = i_tms ? c_st_seldr : c_st_rti;
            c_st_seldr: w_next = i_tms ? c_st_selir : c_st_cdr;
            c_st_cdr:   w_next = i_tms ? c_st_e1dr  : c_st_sdr;
            c_st_sdr:   w_next = i_tms ? c_st_e1dr  : c_st_sdr;
            c_st_e1dr:  w_next = i_tms ? c_st_udr   : c_st_pdr;
            c_st_pdr:   w_next = i_tms ? c_st_e2dr  : c_st_pdr;
            c_st_e2dr:  w_next = i_tms ? c_st_udr   : c_st_sdr;
            c_st_udr:   w_next = i_tms ? c_st_seldr : c_st_rti;
            c_st_selir: w_next = i_tms ? c_st_tlr   : c_st_cir;
            c_st_cir:   w_next = i_tms ? c_st_e1ir  : c_st_sir;
            c_st_sir:   w_next = i_tms ? c_st_e1ir  : c_st_sir;
            c_st_e1ir:  w_next = i_tms ? c_st_uir   : c_st_pir;
            c_st_pir:   w_next = i_tms ? c_st_e2ir  : c_st_pir;
            c_st_e2ir:  w_next = i_tms ? c_st_uir   : c_st_sir;
            c_st_uir:   w_next = i_tms ? c_st_seldr : c_st_rti;
            default:    w_next = c_st_tlr;
        endcase
    end

    always_ff @(posedge tck) begin
        if (reset) begin
            r_state <= c_st_tlr;
        end else begin
            r_state <= w_next;
        end
    end

    assign o_state = r_state;
    assign o_cdr   = (r_state == c_st_cdr);
    assign o_sdr   = (r_state == c_st_sdr);
    assign o_e1dr  = (r_state == c_st_e1dr);
    assign o_pdr   = (r_state == c_st_pdr);
    assign o_e2dr  = (r_state == c_st_e2dr);
    assign o_udr   = (r_state == c_st_udr);
    assign o_cir   = (r_state == c_st_cir);
    assign o_uir   = (r_state == c_st_uir);

endmodule
`default_nettype wire

// File: rtl/virtual_jtag.sv
`default_nettype none
// ============================================================================
// Module      : virtual_jtag
// Description : Soft virtual-JTAG hub: TAP FSM, user IR shifter and TDO mux.
//               VJTAG_IR_CAPTURE_EN: Capture-IR loads ir_out instead of 0..01.
// Revision    : 1.0 - initial release
// ============================================================================
module virtual_jtag
    import vjtag_pkg::*;
#(
    parameter int                      SLD_IR_WIDTH   = 4,
    parameter logic [SLD_IR_WIDTH-1:0] IR_RESET_VALUE = '0
) (
    input  logic                    tck,
    input  logic                    reset,
    input  logic                    jtag_tms,
    input  logic                    jtag_tdi,
    output logic                    jtag_tdo,
    output logic                    tms,
    output logic                    tdi,
    input  logic                    tdo,
    input  logic [SLD_IR_WIDTH-1:0] ir_out,
    output logic [SLD_IR_WIDTH-1:0] ir_in,
    output logic                    virtual_state_cdr,
    output logic                    virtual_state_sdr,
    output logic                    virtual_state_e1dr,
    output logic                    virtual_state_pdr,
    output logic                    virtual_state_e2dr,
    output logic                    virtual_state_udr,
    output logic                    virtual_state_cir,
    output logic                    virtual_state_uir
);

    if (SLD_IR_WIDTH < c_ir_width_min || SLD_IR_WIDTH > c_ir_width_max) begin : g_width_check
        $error("virtual_jtag: SLD_IR_WIDTH out of range");
    end

    logic [3:0]              w_state;
    logic [SLD_IR_WIDTH-1:0] r_ir_sr;
    logic [SLD_IR_WIDTH-1:0] r_ir_in;
    logic [SLD_IR_WIDTH-1:0] w_capture;
    logic [SLD_IR_WIDTH-1:0] w_shift;

    vjtag_tap_fsm u_tap_fsm (
        .tck     (tck),
        .reset   (reset),
        .i_tms   (jtag_tms),
        .o_state (w_state),
        .o_cdr   (virtual_state_cdr),
        .o_sdr   (virtual_state_sdr),
        .o_e1dr  (virtual_state_e1dr),
        .o_pdr   (virtual_state_pdr),
        .o_e2dr  (virtual_state_e2dr),
        .o_udr   (virtual_state_udr),
        .o_cir   (virtual_state_cir),
        .o_uir   (virtual_state_uir)
    );

`ifdef VJTAG_IR_CAPTURE_EN
    assign w_capture = ir_out;
`else
    logic w_unused_ir_out;
    assign w_unused_ir_out = ^ir_out;
    assign w_capture       = SLD_IR_WIDTH'(1);
`endif

    // LSB-first shift; a 1-bit IR simply takes TDI.
    if (SLD_IR_WIDTH == 1) begin : g_shift_one
        assign w_shift = jtag_tdi;
    end else begin : g_shift_wide
        assign w_shift = {jtag_tdi, r_ir_sr[SLD_IR_WIDTH-1:1]};
    end

    always_ff @(posedge tck) begin
        if (reset) begin
            r_ir_sr <= '0;
            r_ir_in <= IR_RESET_VALUE;
        end else begin
            if (w_state == c_st_cir) begin
                r_ir_sr <= w_capture;
            end else if (w_state == c_st_sir) begin
                r_ir_sr <= w_shift;
            end
            if (w_state == c_st_uir) begin
                r_ir_in <= r_ir_sr;
            end else if (w_state == c_st_tlr) begin
                r_ir_in <= IR_RESET_VALUE;
            end
        end
    end

    assign ir_in    = r_ir_in;
    assign tms      = jtag_tms;
    assign tdi      = jtag_tdi;
    assign jtag_tdo = (w_state == c_st_sir) ? r_ir_sr[0] :
                      (w_state == c_st_sdr) ? tdo        : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_virtual_jtag.sv
`default_nettype none
// ============================================================================
// Module      : tb_virtual_jtag
// Description : Directed self-checking bench for virtual_jtag (W=4, reset 0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_virtual_jtag;

    localparam logic [7:0] c_d_none = 8'h00;
    localparam logic [7:0] c_d_cdr  = 8'h80;
    localparam logic [7:0] c_d_sdr  = 8'h40;
    localparam logic [7:0] c_d_e1dr = 8'h20;
    localparam logic [7:0] c_d_pdr  = 8'h10;
    localparam logic [7:0] c_d_e2dr = 8'h08;
    localparam logic [7:0] c_d_udr  = 8'h04;
    localparam logic [7:0] c_d_cir  = 8'h02;
    localparam logic [7:0] c_d_uir  = 8'h01;

    logic       tck = 1'b0;
    logic       reset;
    logic       jtag_tms;
    logic       jtag_tdi;
    logic       jtag_tdo;
    logic       tms;
    logic       tdi;
    logic       tdo;
    logic [3:0] ir_out;
    logic [3:0] ir_in;
    logic       v_cdr, v_sdr, v_e1dr, v_pdr, v_e2dr, v_udr, v_cir, v_uir;
    logic [7:0] w_dec;

    int checks   = 0;
    int failures = 0;

    assign w_dec = {v_cdr, v_sdr, v_e1dr, v_pdr, v_e2dr, v_udr, v_cir, v_uir};

    virtual_jtag #(.SLD_IR_WIDTH(4), .IR_RESET_VALUE(4'h0)) dut (
        .tck                (tck),
        .reset              (reset),
        .jtag_tms           (jtag_tms),
        .jtag_tdi           (jtag_tdi),
        .jtag_tdo           (jtag_tdo),
        .tms                (tms),
        .tdi                (tdi),
        .tdo                (tdo),
        .ir_out             (ir_out),
        .ir_in              (ir_in),
        .virtual_state_cdr  (v_cdr),
        .virtual_state_sdr  (v_sdr),
        .virtual_state_e1dr (v_e1dr),
        .virtual_state_pdr  (v_pdr),
        .virtual_state_e2dr (v_e2dr),
        .virtual_state_udr  (v_udr),
        .virtual_state_cir  (v_cir),
        .virtual_state_uir  (v_uir)
    );

    always #5 tck = ~tck;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic t_ms, input logic t_di);
        jtag_tms = t_ms;
        jtag_tdi = t_di;
        @(posedge tck);
        #1;
    endtask

    initial begin
        logic [3:0]  cap_exp;
        logic [3:0]  tdi_pat;
        logic [31:0] dr_pat;

        reset    = 1'b1;
        jtag_tms = 1'b1;
        jtag_tdi = 1'b0;
        tdo      = 1'b0;
        ir_out   = 4'h6;
`ifdef VJTAG_IR_CAPTURE_EN
        cap_exp = 4'h6;
`else
        cap_exp = 4'h1;
`endif
        tdi_pat = 4'b0011;
        dr_pat  = 32'hC3A5_96E1;

        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("rst_dec", w_dec, c_d_none);
        check("rst_ir_in", ir_in, 4'h0);
        check("rst_tdo", jtag_tdo, 1'b0);
        reset = 1'b0;

        // Pass-through of TMS/TDI
        jtag_tms = 1'b1; jtag_tdi = 1'b0; #1;
        check("pass_tms_tdi", {tms, tdi}, 2'b10);
        jtag_tms = 1'b0; jtag_tdi = 1'b1; #1;
        check("pass_tms_tdi2", {tms, tdi}, 2'b01);

        // IR load: shift 0,1,0,1 LSB first -> 4'hA
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("load_cir", w_dec, c_d_cir);
        step(1'b0, 1'b0);
        check("load_sir", w_dec, c_d_none);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        check("load_e1ir_ir_in", ir_in, 4'h0);
        step(1'b1, 1'b0);
        check("load_uir", w_dec, c_d_uir);
        check("load_uir_ir_in", ir_in, 4'h0);
        step(1'b0, 1'b0);
        check("load_uir_one_cycle", w_dec, c_d_none);
        check("load_ir_in", ir_in, 4'hA);

        // TMS reset from PDR
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("tmsrst_pdr", w_dec, c_d_pdr);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        check("tmsrst_tlr_dec", w_dec, c_d_none);
        check("tmsrst_tlr_ir_hold", ir_in, 4'hA);
        step(1'b0, 1'b0);
        check("tmsrst_ir_in", ir_in, 4'h0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("tmsrst_rti_path", w_dec, c_d_cdr);

        // Back to RTI via E1DR/UDR, then IR capture readback
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("cap_udr", w_dec, c_d_udr);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("cap_cir", w_dec, c_d_cir);
        step(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("cap_tdo%0d", k), jtag_tdo, cap_exp[k]);
            step(k == 3, tdi_pat[k]);
        end
        check("cap_e1ir", w_dec, c_d_none);
        step(1'b1, 1'b0);
        check("cap_uir", w_dec, c_d_uir);
        step(1'b0, 1'b0);
        check("cap_ir_in", ir_in, 4'h3);

        // DR sequence
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("dr_cdr", w_dec, c_d_cdr);
        check("dr_cdr_tdo", jtag_tdo, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            tdo = dr_pat[i];
            #1;
            check($sformatf("dr_sdr%0d", i), {w_dec, 3'b000, jtag_tdo}, {c_d_sdr, 3'b000, dr_pat[i]});
            step(i == 31, 1'b0);
        end
        tdo = 1'b1;
        #1;
        check("dr_e1dr", {w_dec, 3'b000, jtag_tdo}, {c_d_e1dr, 4'h0});
        step(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("dr_pdr%0d", i), w_dec, c_d_pdr);
            step(i == 2, 1'b0);
        end
        check("dr_e2dr", w_dec, c_d_e2dr);
        step(1'b0, 1'b0);
        check("dr_sdr_b0", w_dec, c_d_sdr);
        step(1'b0, 1'b0);
        check("dr_sdr_b1", w_dec, c_d_sdr);
        step(1'b1, 1'b0);
        check("dr_e1dr_b", w_dec, c_d_e1dr);
        step(1'b1, 1'b0);
        check("dr_udr", w_dec, c_d_udr);
        step(1'b0, 1'b0);
        check("dr_rti", w_dec, c_d_none);
        check("dr_ir_in", ir_in, 4'h3);

        // Synchronous reset from SDR
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        tdo = 1'b1;
        #1;
        check("srst_pre_sdr", {w_dec, 3'b000, jtag_tdo}, {c_d_sdr, 4'h1});
        reset = 1'b1;
        step(1'b0, 1'b0);
        check("srst_dec", w_dec, c_d_none);
        check("srst_tdo", jtag_tdo, 1'b0);
        check("srst_ir_in", ir_in, 4'h0);
        reset = 1'b0;
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("srst_tlr_path", w_dec, c_d_cdr);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/virtual_jtag.md
# virtual_jtag

Soft replacement for the vendor virtual-JTAG hub. It implements an IEEE 1149.1 TAP state machine clocked by `tck`, plus a user instruction register of `SLD_IR_WIDTH` bits. It exposes one-hot "virtual state" decodes so user logic (`jtag_tap`, `system`) can run its own data registers. It sits between the physical JTAG pins and the user DR logic; TMS/TDI pass through, and TDO is muxed between the IR and the user DR.

## Interface
- `SLD_IR_WIDTH`, default 4: user IR width, from 1 to 16.
- `IR_RESET_VALUE`, default 0: value loaded into `ir_in` on reset and in Test-Logic-Reset.
- `tck` in 1: the single clock. All state changes on the rising edge. User logic shares this net.
- `reset` in 1: synchronous, active-high reset.
- `jtag_tms`, `jtag_tdi` in 1: physical JTAG inputs.
- `jtag_tdo` out 1: physical JTAG output.
- `tms`, `tdi` out 1: combinational pass-through of `jtag_tms` and `jtag_tdi` to user logic.
- `tdo` in 1: user DR serial output.
- `ir_out` in W: value captured into the IR shifter at Capture-IR.
- `ir_in` out W: current user instruction.
- `virtual_state_cdr`, `_sdr`, `_e1dr`, `_pdr`, `_e2dr`, `_udr`, `_cir`, `_uir` out 1 each: state decodes.

## Operation
- Standard 16-state TAP FSM. States: TLR, RTI, SELDR, CDR, SDR, E1DR, PDR, E2DR, UDR, SELIR, CIR, SIR, E1IR, PIR, E2IR, UIR.
- Transitions (tms=0 / tms=1):
  - TLR: RTI / TLR
  - RTI: RTI / SELDR
  - SELDR: CDR / SELIR
  - CDR, SDR: SDR / E1DR
  - E1DR: PDR / UDR
  - PDR: PDR / E2DR
  - E2DR: SDR / UDR
  - UDR, UIR: RTI / SELDR
  - SELIR: CIR / TLR
  - The IR branch mirrors the DR branch.
- Five consecutive edges with `jtag_tms`=1 reach TLR from any state.
- IR shifter `ir_sr` (W bits):
  - In CIR: `ir_sr` loads `ir_out`.
  - In SIR: `ir_sr` <= {`jtag_tdi`, `ir_sr`[W-1:1]`}`, so the LSB enters first.
  - In UIR: `ir_in` <= `ir_sr`.
  - In TLR: `ir_in` <= `IR_RESET_VALUE`.
- `jtag_tdo` (combinational) is `ir_sr`[0] in SIR, `tdo` in SDR, and 0 otherwise.
- Each `virtual_state_x` is 1 exactly while the FSM is in that state. It is combinational from the state register.
- DR contents are entirely user-owned. The block never shifts DR data itself.

## Timing
- Reset (`reset`=1 at an edge) gives:
  - state = TLR
  - `ir_sr` = 0
  - `ir_in` = `IR_RESET_VALUE`
  - all `virtual_state_*` = 0
  - `jtag_tdo` = 0
- `reset` overrides TMS. Reset asserted mid-shift discards `ir_sr` and leaves `ir_in` at `IR_RESET_VALUE`.
- TMS is sampled on the rising edge, and the new state is visible one cycle later. Example: `jtag_tms` 0 at an edge while in SELDR makes `virtual_state_cdr`=1 for the following cycle.
- Each CDR, UDR, CIR and UIR visit lasts exactly one `tck` cycle. `sdr` stays high for N cycles for an N-bit shift (tms=0 held N-1 edges, then tms=1).
- `ir_in` changes on the edge that ends the UIR cycle, and is stable from the next cycle until the next UIR or TLR.
- The last SIR cycle, where tms=1, still shifts. The shifter holds in E1IR, PIR and E2IR.
- When W bits are shifted, the bits sampled on those W edges land in `ir_sr`[0..W-1] in arrival order.

## Configuration
- `VJTAG_IR_CAPTURE_EN` defined: CIR loads `ir_out`, as described above.
- Undefined: CIR loads the constant {0…0,1}, the IEEE capture pattern, and `ir_out` is ignored.

## Structure
- Package `vjtag_pkg` holds the 4-bit state encoding constants (TLR=4'hF, RTI=4'hC, SELDR=4'h7, CDR=4'h6, SDR=4'h2, E1DR=4'h1, PDR=4'h3, E2DR=4'h0, UDR=4'h5, SELIR=4'h4, CIR=4'hE, SIR=4'hA, E1IR=4'h9, PIR=4'hB, E2IR=4'h8, UIR=4'hD) and the width limits.
- One sub-module, `vjtag_tap_fsm`, contains the state register, the next-state logic and the decodes. The top level adds the IR shifter, `ir_in` and the TDO mux.

## Test plan
- Reset: pulse `reset` from SDR -> state TLR, `ir_in`=0, all decodes 0, `jtag_tdo`=0.
- TMS reset: from PDR, apply five edges with tms=1 -> TLR. Then tms=0 -> RTI.
- IR load, W=4: TMS path to SIR, shift tdi 0,1,0,1 (LSB first, tms=1 on the 4th), then through E1IR to UIR. Expect `ir_in`=4'hA one cycle after UIR, and `virtual_state_uir` high for exactly 1 cycle.
- IR capture with macro defined: `ir_out`=4'h6; CIR then 4 SIR cycles -> `jtag_tdo` reads 0,1,1,0. With macro undefined it reads 1,0,0,0.
- DR sequence: CDR for 1 cycle, then 32 cycles of SDR with `jtag_tdo` following `tdo`, then E1DR, PDR for 3 cycles, E2DR, SDR for 2 cycles, E1DR, UDR for 1 cycle. Each decode is high only in its state, and `ir_in` is unchanged throughout.
